// File: rtl/reaction_ctrl_pkg.sv
// reaction_ctrl_pkg: shared state encoding and BCD constants for the reaction-timer sequencer
package reaction_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DONE,
        S_CHEAT,
        S_TIMEOUT
    } state_t;

    localparam logic [11:0] BCD_999  = 12'h999;
    localparam logic [11:0] BEST_RST = BCD_999;

endpackage

// File: rtl/rt_delay_timer.sv
// rt_delay_timer: loadable tick-driven down-counter for the random pre-stimulus delay
// Ports: clk/ar clock and async active-low reset; load/load_val arm the delay;
//        tick decrements; expire pulses on the tick that consumes the last count;
//        busy is high while a delay remains.
module rt_delay_timer #(
    parameter int DLY_W = 16
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             tick,
    output logic             expire,
    output logic             busy
);

    logic [DLY_W-1:0] dly_q, dly_d;

    always_comb begin
        busy   = dly_q != '0;
        expire = tick & (dly_q == DLY_W'(1));
        dly_d  = load ? load_val : (tick && busy) ? dly_q - DLY_W'(1) : dly_q;
    end

    always_ff @(posedge clk or negedge ar)
        if (!ar) dly_q <= '0;
        else     dly_q <= dly_d;

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-timer trial sequencer driving the BCD counter and tracking best time
// Ports: clk/ar clock and async active-low reset; tick 1 ms strobe; start_btn/react_btn
//        debounced buttons; lfsr_val random seed; dig1..dig3 counter digits (ones..hundreds);
//        ctr_en/ctr_ar counter enable and registered active-low clear; lamp/cheat/timeout
//        status; new_best one-cycle pulse; best1..best3 best time in BCD.
module reaction_ctrl
    import reaction_ctrl_pkg::*;
#(
    parameter int DLY_W     = 16,
    parameter int LFSR_W    = 8,
    parameter int MIN_DLY   = 1000,
    parameter int DLY_SHIFT = 3
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              tick,
    input  logic              start_btn,
    input  logic              react_btn,
    input  logic [LFSR_W-1:0] lfsr_val,
    input  logic [3:0]        dig1,
    input  logic [3:0]        dig2,
    input  logic [3:0]        dig3,
    output logic              ctr_en,
    output logic              ctr_ar,
    output logic              lamp,
    output logic              cheat,
    output logic              timeout,
    output logic              new_best,
    output logic [3:0]        best1,
    output logic [3:0]        best2,
    output logic [3:0]        best3
);

    state_t      state_q, state_d;
    logic        start_prev_q, start_prev_d;
    logic        react_prev_q, react_prev_d;
    logic        ctr_ar_q, ctr_ar_d;
    logic [11:0] best_q, best_d;
    logic        start_edge, react_edge, arm, at_999, expire, busy;
    logic [11:0] cnt;

    rt_delay_timer #(.DLY_W(DLY_W)) u_dly (
        .clk     (clk),
        .ar      (ar),
        .load    (arm),
        .load_val(DLY_W'(MIN_DLY) + (DLY_W'(lfsr_val) << DLY_SHIFT)),
        .tick    (tick & (state_q == S_WAIT)),
        .expire  (expire),
        .busy    (busy)
    );

    always_comb begin
        start_prev_d = start_btn;
        react_prev_d = react_btn;
        start_edge   = start_btn & ~start_prev_q;
        react_edge   = react_btn & ~react_prev_q;
        cnt          = {dig3, dig2, dig1};
        at_999       = cnt == BCD_999;
        arm          = start_edge & (state_q != S_WAIT) & (state_q != S_RUN);
        ctr_ar_d     = ~arm;
        // Holding the enable off at 999 keeps the count from wrapping before TIMEOUT is entered.
        ctr_en       = (state_q == S_RUN) & tick & ~react_edge & ~at_999;
        // Once loaded, best equals the frozen count, so the compare itself ends the pulse.
        new_best     = (state_q == S_DONE) & (cnt < best_q);
        best_d       = new_best ? cnt : best_q;
        lamp         = state_q == S_RUN;
        cheat        = state_q == S_CHEAT;
        timeout      = state_q == S_TIMEOUT;
        state_d      = state_q;
        case (state_q)
            // An empty timer (zero-length delay) falls straight through to RUN.
            S_WAIT:  state_d = react_edge ? S_CHEAT : (expire || !busy) ? S_RUN : S_WAIT;
            S_RUN:   state_d = at_999 ? S_TIMEOUT : react_edge ? S_DONE : S_RUN;
            default: state_d = arm ? S_WAIT : state_q;
        endcase
    end

    always_ff @(posedge clk or negedge ar)
        if (!ar) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            react_prev_q <= 1'b0;
            ctr_ar_q     <= 1'b1;
            best_q       <= BEST_RST;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            react_prev_q <= react_prev_d;
            ctr_ar_q     <= ctr_ar_d;
            best_q       <= best_d;
        end

    assign ctr_ar = ctr_ar_q;
    assign {best3, best2, best1} = best_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: directed self-checking bench for reaction_ctrl with a behavioural BCD counter
module tb_reaction_ctrl;

    logic       clk = 1'b0, ar = 1'b0, tick = 1'b0, start_btn = 1'b0, react_btn = 1'b0;
    logic [7:0] lfsr_val = 8'h00;
    logic [3:0] dig1 = 4'd0, dig2 = 4'd0, dig3 = 4'd0;
    logic       ctr_en, ctr_ar, lamp, cheat, timeout, new_best;
    logic [3:0] best1, best2, best3;
    int         n_chk = 0, n_fail = 0;
    int         nb_cnt = 0, en_cnt = 0, lamp_cnt = 0;

    always #5 clk = ~clk;

    reaction_ctrl dut (
        .clk(clk), .ar(ar), .tick(tick), .start_btn(start_btn), .react_btn(react_btn),
        .lfsr_val(lfsr_val), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .ctr_en(ctr_en), .ctr_ar(ctr_ar), .lamp(lamp), .cheat(cheat), .timeout(timeout),
        .new_best(new_best), .best1(best1), .best2(best2), .best3(best3)
    );

    // Stand-in for the bcd_ctr instance the block drives.
    always_ff @(posedge clk or negedge ctr_ar)
        if (!ctr_ar) {dig3, dig2, dig1} <= 12'h000;
        else if (ctr_en) begin
            if (dig1 != 4'd9) dig1 <= dig1 + 4'd1;
            else begin
                dig1 <= 4'd0;
                if (dig2 != 4'd9) dig2 <= dig2 + 4'd1;
                else begin
                    dig2 <= 4'd0;
                    dig3 <= (dig3 == 4'd9) ? 4'd0 : dig3 + 4'd1;
                end
            end
        end

    always @(posedge clk) begin
        if (new_best) nb_cnt <= nb_cnt + 1;
        if (ctr_en) en_cnt <= en_cnt + 1;
        if (lamp) lamp_cnt <= lamp_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press_start(input logic [7:0] v);
        lfsr_val = v;
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_react;
        react_btn = 1'b1;
        @(negedge clk);
        react_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_trial(input int n);
        press_start(8'h00);
        ticks(1000);
        ticks(n);
        press_react();
    endtask

    task automatic test_reset;
        ar = 1'b0;
        cyc(2);
        n_chk++; if (ctr_en !== 1'b0) begin n_fail++; $display("FAIL reset_ctr_en: got %b want 0", ctr_en); end
        n_chk++; if (ctr_ar !== 1'b1) begin n_fail++; $display("FAIL reset_ctr_ar: got %b want 1", ctr_ar); end
        n_chk++; if ({lamp, cheat, timeout, new_best} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {lamp, cheat, timeout, new_best}); end
        n_chk++; if ({best3, best2, best1} !== 12'h999) begin n_fail++; $display("FAIL reset_best: got %h want 999", {best3, best2, best1}); end
        ar = 1'b1;
        cyc(2);
        n_chk++; if ({lamp, ctr_ar, ctr_en} !== 3'b010) begin n_fail++; $display("FAIL post_reset_idle: got %b want 010", {lamp, ctr_ar, ctr_en}); end
    endtask

    task automatic test_basic;
        int nb0;
        lfsr_val = 8'h00;
        start_btn = 1'b1;
        @(negedge clk);
        n_chk++; if (ctr_ar !== 1'b0) begin n_fail++; $display("FAIL basic_clear_low: got %b want 0", ctr_ar); end
        start_btn = 1'b0;
        @(negedge clk);
        n_chk++; if (ctr_ar !== 1'b1) begin n_fail++; $display("FAIL basic_clear_high: got %b want 1", ctr_ar); end
        ticks(999);
        n_chk++; if (lamp !== 1'b0) begin n_fail++; $display("FAIL basic_lamp_999: got %b want 0", lamp); end
        ticks(1);
        n_chk++; if (lamp !== 1'b1) begin n_fail++; $display("FAIL basic_lamp_1000: got %b want 1", lamp); end
        ticks(237);
        n_chk++; if ({dig3, dig2, dig1} !== 12'h237) begin n_fail++; $display("FAIL basic_count: got %h want 237", {dig3, dig2, dig1}); end
        nb0 = nb_cnt;
        react_btn = 1'b1;
        @(negedge clk);
        n_chk++; if (new_best !== 1'b1) begin n_fail++; $display("FAIL basic_new_best: got %b want 1", new_best); end
        n_chk++; if ({best3, best2, best1} !== 12'h999) begin n_fail++; $display("FAIL basic_best_early: got %h want 999", {best3, best2, best1}); end
        react_btn = 1'b0;
        @(negedge clk);
        n_chk++; if ({best3, best2, best1} !== 12'h237) begin n_fail++; $display("FAIL basic_best: got %h want 237", {best3, best2, best1}); end
        n_chk++; if (lamp !== 1'b0) begin n_fail++; $display("FAIL basic_lamp_done: got %b want 0", lamp); end
        cyc(3);
        n_chk++; if (nb_cnt - nb0 !== 1) begin n_fail++; $display("FAIL basic_pulse_count: got %0d want 1", nb_cnt - nb0); end
        n_chk++; if ({dig3, dig2, dig1} !== 12'h237) begin n_fail++; $display("FAIL basic_frozen: got %h want 237", {dig3, dig2, dig1}); end
    endtask

    task automatic test_cheat;
        int e0, l0;
        e0 = en_cnt;
        l0 = lamp_cnt;
        press_start(8'hFF);
        ticks(499);
        tick = 1'b1;
        react_btn = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        react_btn = 1'b0;
        @(negedge clk);
        n_chk++; if (cheat !== 1'b1) begin n_fail++; $display("FAIL cheat_flag: got %b want 1", cheat); end
        ticks(2600);
        n_chk++; if (cheat !== 1'b1) begin n_fail++; $display("FAIL cheat_hold: got %b want 1", cheat); end
        n_chk++; if (lamp_cnt - l0 !== 0) begin n_fail++; $display("FAIL cheat_lamp_cycles: got %0d want 0", lamp_cnt - l0); end
        n_chk++; if (en_cnt - e0 !== 0) begin n_fail++; $display("FAIL cheat_en_cycles: got %0d want 0", en_cnt - e0); end
        n_chk++; if ({best3, best2, best1} !== 12'h237) begin n_fail++; $display("FAIL cheat_best: got %h want 237", {best3, best2, best1}); end
    endtask

    task automatic test_timeout;
        int e0, nb0;
        nb0 = nb_cnt;
        press_start(8'h00);
        ticks(1000);
        ticks(999);
        n_chk++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b want 1", timeout); end
        n_chk++; if ({dig3, dig2, dig1} !== 12'h999) begin n_fail++; $display("FAIL timeout_count: got %h want 999", {dig3, dig2, dig1}); end
        e0 = en_cnt;
        ticks(5);
        press_react();
        n_chk++; if ({timeout, cheat, lamp} !== 3'b100) begin n_fail++; $display("FAIL timeout_react_ignored: got %b want 100", {timeout, cheat, lamp}); end
        n_chk++; if (en_cnt - e0 !== 0) begin n_fail++; $display("FAIL timeout_en_cycles: got %0d want 0", en_cnt - e0); end
        n_chk++; if ({dig3, dig2, dig1} !== 12'h999) begin n_fail++; $display("FAIL timeout_hold: got %h want 999", {dig3, dig2, dig1}); end
        n_chk++; if (nb_cnt - nb0 !== 0) begin n_fail++; $display("FAIL timeout_pulses: got %0d want 0", nb_cnt - nb0); end
        n_chk++; if ({best3, best2, best1} !== 12'h237) begin n_fail++; $display("FAIL timeout_best: got %h want 237", {best3, best2, best1}); end
    endtask

    task automatic test_reset_mid_run;
        press_start(8'h00);
        ticks(1050);
        n_chk++; if ({lamp, dig3, dig2, dig1} !== 13'h1050) begin n_fail++; $display("FAIL midrun_setup: got %h want 1050", {lamp, dig3, dig2, dig1}); end
        tick = 1'b1;
        ar = 1'b0;
        #1;
        n_chk++; if ({lamp, ctr_en, ctr_ar, cheat, timeout, new_best} !== 6'b001000) begin n_fail++; $display("FAIL midrun_outputs: got %b want 001000", {lamp, ctr_en, ctr_ar, cheat, timeout, new_best}); end
        n_chk++; if ({best3, best2, best1} !== 12'h999) begin n_fail++; $display("FAIL midrun_best: got %h want 999", {best3, best2, best1}); end
        n_chk++; if ({dig3, dig2, dig1} !== 12'h050) begin n_fail++; $display("FAIL midrun_count_kept: got %h want 050", {dig3, dig2, dig1}); end
        tick = 1'b0;
        @(negedge clk);
        ar = 1'b1;
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        n_chk++; if ({ctr_ar, dig3, dig2, dig1} !== 13'h0000) begin n_fail++; $display("FAIL midrun_restart_clear: got %h want 0000", {ctr_ar, dig3, dig2, dig1}); end
        start_btn = 1'b0;
        @(negedge clk);
        n_chk++; if (ctr_ar !== 1'b1) begin n_fail++; $display("FAIL midrun_clear_one_cycle: got %b want 1", ctr_ar); end
        press_react();
    endtask

    task automatic test_best_rules;
        int nb0;
        nb0 = nb_cnt;
        run_trial(300);
        n_chk++; if ({best3, best2, best1} !== 12'h300) begin n_fail++; $display("FAIL best_first: got %h want 300", {best3, best2, best1}); end
        n_chk++; if (nb_cnt - nb0 !== 1) begin n_fail++; $display("FAIL best_first_pulse: got %0d want 1", nb_cnt - nb0); end
        run_trial(300);
        n_chk++; if (nb_cnt - nb0 !== 1) begin n_fail++; $display("FAIL best_equal_pulse: got %0d want 1", nb_cnt - nb0); end
        run_trial(150);
        n_chk++; if (nb_cnt - nb0 !== 2) begin n_fail++; $display("FAIL best_third_pulse: got %0d want 2", nb_cnt - nb0); end
        n_chk++; if ({best3, best2, best1} !== 12'h150) begin n_fail++; $display("FAIL best_final: got %h want 150", {best3, best2, best1}); end
    endtask

    task automatic test_simultaneous;
        press_start(8'h00);
        ticks(999);
        tick = 1'b1;
        react_btn = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        react_btn = 1'b0;
        @(negedge clk);
        n_chk++; if ({cheat, lamp} !== 2'b10) begin n_fail++; $display("FAIL sim_expiry_cheat: got %b want 10", {cheat, lamp}); end
        press_start(8'h00);
        ticks(1041);
        tick = 1'b1;
        react_btn = 1'b1;
        #1;
        n_chk++; if (ctr_en !== 1'b0) begin n_fail++; $display("FAIL sim_run_en: got %b want 0", ctr_en); end
        @(negedge clk);
        tick = 1'b0;
        react_btn = 1'b0;
        @(negedge clk);
        n_chk++; if ({dig3, dig2, dig1} !== 12'h041) begin n_fail++; $display("FAIL sim_run_frozen: got %h want 041", {dig3, dig2, dig1}); end
        n_chk++; if ({best3, best2, best1} !== 12'h041) begin n_fail++; $display("FAIL sim_run_best: got %h want 041", {best3, best2, best1}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cheat();
        test_timeout();
        test_reset_mid_run();
        test_best_rules();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
